// File: rtl/uart_pkg.sv
// Shared constants for the UART byte-stream path: IRQ cause bit positions,
// default FIFO geometry and the system clock rate used by the baud divider.
package uart_pkg;

  localparam int unsigned IRQ_CAUSE_WM = 0;
  localparam int unsigned IRQ_CAUSE_TO = 1;

  localparam int unsigned DEF_DATA_WIDTH     = 8;
  localparam int unsigned DEF_DEPTH          = 8;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 40000000;

  localparam int unsigned CLK_HZ = 40000000;

endpackage

// File: rtl/uart_fifo_irq_gen.sv
// Batch interrupt generator: watermark rising-edge detect, optional idle
// timeout (UART_FIFO_TIMEOUT_EN) and the held irq_cause register.
module uart_fifo_irq_gen
  import uart_pkg::*;
#(
  parameter int unsigned LEVEL_W        = 4,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic [LEVEL_W-1:0] level,
  input  logic [LEVEL_W-1:0] watermark,
  input  logic               push_ok,
  input  logic               pop_ok,
  output logic               irq,
  output logic [1:0]         irq_cause
);

  logic       wm_hit;
  logic       wm_fire;
  logic       to_fire;
  logic       wm_hit_q;
  logic       irq_q;
  logic [1:0] cause_q;

  assign wm_hit  = (watermark != '0) && (level >= watermark);
  assign wm_fire = wm_hit && !wm_hit_q;

`ifdef UART_FIFO_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

  logic [31:0] idle_cnt_q;
  logic [31:0] idle_cnt_d;

  always_comb begin
    idle_cnt_d = '0;
    to_fire    = 1'b0;
    if (clr || (level == '0) || push_ok || pop_ok) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q == TO_LAST) begin
      to_fire    = 1'b1;
      idle_cnt_d = '0;
    end else begin
      idle_cnt_d = idle_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idle_cnt_q <= '0;
    else        idle_cnt_q <= idle_cnt_d;
  end
`else
  logic unused_to;
  assign to_fire   = 1'b0;
  assign unused_to = push_ok ^ pop_ok ^ (TIMEOUT_CYCLES == 0);
`endif

  // Cause is only rewritten when a pulse fires, so it reads back until the next irq.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wm_hit_q <= 1'b0;
      irq_q    <= 1'b0;
      cause_q  <= '0;
    end else if (clr) begin
      wm_hit_q <= 1'b0;
      irq_q    <= 1'b0;
      cause_q  <= '0;
    end else begin
      wm_hit_q <= wm_hit;
      irq_q    <= wm_fire || to_fire;
      if (wm_fire || to_fire) begin
        cause_q[IRQ_CAUSE_WM] <= wm_fire;
        cause_q[IRQ_CAUSE_TO] <= to_fire;
      end
    end
  end

  assign irq       = irq_q;
  assign irq_cause = cause_q;

endmodule

// File: rtl/uart_stream_fifo.sv
// Parametrised byte-stream FIFO with occupancy level, sticky error flags and a
// batch interrupt; idle-timeout interrupt is enabled by UART_FIFO_TIMEOUT_EN.
module uart_stream_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH          = DEF_DEPTH,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     rd_en,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  input  logic [$clog2(DEPTH):0]   watermark,
  output logic                     irq,
  output logic [1:0]               irq_cause,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  push_ok;
  logic                  pop_ok;

  assign empty = (level_q == '0);
  assign full  = (level_q == LW'(DEPTH));

  // A pop frees a slot in the same cycle, so a full FIFO still takes the push.
  assign pop_ok  = !clr && rd_en && !empty;
  assign push_ok = !clr && wr_en && (!full || pop_ok);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok) begin
        rd_ptr_d   = rd_ptr_q + AW'(1);
        rd_data_d  = mem_q[rd_ptr_q];
        rd_valid_d = 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
      if (wr_en && !push_ok) ovf_d = 1'b1;
      if (rd_en && empty)    unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data;
  end

  uart_fifo_irq_gen #(
    .LEVEL_W        (LW),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_irq_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .level     (level_q),
    .watermark (watermark),
    .push_ok   (push_ok),
    .pop_ok    (pop_ok),
    .irq       (irq),
    .irq_cause (irq_cause)
  );

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign level     = level_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_uart_stream_fifo.sv
// Self-checking bench for uart_stream_fifo: directed scenarios plus random
// traffic, compared against a queue-based reference model.
module tb_uart_stream_fifo;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned LW    = 4;
  localparam int unsigned TO    = 100;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clr;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          full;
  logic          empty;
  logic [LW-1:0] level;
  logic [LW-1:0] watermark;
  logic          irq;
  logic [1:0]    irq_cause;
  logic          overflow;
  logic          underflow;

  uart_stream_fifo #(
    .DATA_WIDTH     (DW),
    .DEPTH          (DEPTH),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .watermark (watermark),
    .irq       (irq),
    .irq_cause (irq_cause),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: contents as a queue, flags and irq derived from the rules.
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_rd;
  bit            m_rv, m_ovf, m_unf, m_irq, m_prev_hit;
  logic [1:0]    m_cause;
  int unsigned   m_idle;

  task automatic model_reset();
    m_q.delete();
    m_rd = '0; m_rv = 0; m_ovf = 0; m_unf = 0; m_irq = 0; m_prev_hit = 0;
    m_cause = '0; m_idle = 0;
  endtask

  task automatic check_outputs(input string sfx);
    chk({"level", sfx},     32'(level),     32'(m_q.size()));
    chk({"empty", sfx},     32'(empty),     32'(m_q.size() == 0));
    chk({"full", sfx},      32'(full),      32'(m_q.size() == DEPTH));
    chk({"rd_valid", sfx},  32'(rd_valid),  32'(m_rv));
    chk({"rd_data", sfx},   32'(rd_data),   32'(m_rd));
    chk({"irq", sfx},       32'(irq),       32'(m_irq));
    chk({"irq_cause", sfx}, 32'(irq_cause), 32'(m_cause));
    chk({"overflow", sfx},  32'(overflow),  32'(m_ovf));
    chk({"underflow", sfx}, 32'(underflow), 32'(m_unf));
  endtask

  task automatic step(input bit wr, input logic [DW-1:0] d, input bit rd, input bit c);
    int unsigned sz;
    bit push, pop, hit, f_wm, f_to;
    @(negedge clk);
    wr_en = wr; wr_data = d; rd_en = rd; clr = c;
    sz = m_q.size();
    if (c) begin
      m_q.delete();
      m_rv = 0; m_ovf = 0; m_unf = 0; m_irq = 0; m_prev_hit = 0;
      m_cause = '0; m_idle = 0;
    end else begin
      pop  = rd && (sz > 0);
      push = wr && ((sz < DEPTH) || pop);
      m_rv = pop;
      if (pop) m_rd = m_q.pop_front();
      if (push) m_q.push_back(d);
      if (wr && !push) m_ovf = 1;
      if (rd && sz == 0) m_unf = 1;
      hit  = (watermark != 0) && (sz >= watermark);
      f_wm = hit && !m_prev_hit;
      m_prev_hit = hit;
      f_to = 0;
`ifdef UART_FIFO_TIMEOUT_EN
      if (sz != 0 && !push && !pop) begin
        m_idle++;
        if (m_idle == TO) begin
          f_to = 1;
          m_idle = 0;
        end
      end else begin
        m_idle = 0;
      end
`endif
      m_irq = f_wm || f_to;
      if (m_irq) m_cause = {f_to, f_wm};
    end
    @(posedge clk);
    #1;
    check_outputs("");
  endtask

  initial begin
    int unsigned irq_cnt;
    int unsigned first_irq;

    rst_n = 1'b0; clr = 0; wr_en = 0; wr_data = '0; rd_en = 0; watermark = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs("@reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Fill, overflow, drain in order
    for (int i = 0; i < 8; i++) step(1, 8'(8'h11 + i), 0, 0);
    step(1, 8'h99, 0, 0);
    chk("overflow_9th", 32'(overflow), 32'd1);
    for (int i = 0; i < 8; i++) step(0, 8'h00, 1, 0);

    // Full with simultaneous push/pop: pointers wrap, level holds
    for (int i = 0; i < 8; i++) step(1, 8'(8'h11 + i), 0, 0);
    for (int i = 0; i < 4; i++) step(1, 8'hAA, 1, 0);
    chk("full_held", 32'(full), 32'd1);
    for (int i = 0; i < 8; i++) step(0, 8'h00, 1, 0);
    chk("last_pop_AA", 32'(rd_data), 32'hAA);

    // Empty with simultaneous push/pop: pop rejected, push stored
    step(1, 8'h5C, 1, 0);
    chk("empty_pp_level", 32'(level), 32'd1);
    step(0, 8'h00, 1, 0);
    chk("empty_pp_data", 32'(rd_data), 32'h5C);

    // Watermark pulses
    step(0, 8'h00, 0, 1);
    watermark = 4'd4;
    irq_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step(i < 5, 8'(8'h30 + i), 0, 0);
      if (irq) irq_cnt++;
    end
    chk("wm_one_pulse", 32'(irq_cnt), 32'd1);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 1, 0);
    step(1, 8'h40, 0, 0);
    step(0, 8'h00, 0, 0);
    chk("wm_second_pulse", 32'(irq), 32'd1);
    chk("wm_second_cause", 32'(irq_cause), 32'd1);

    // Idle timeout after two pushes
    watermark = '0;
    step(0, 8'h00, 0, 1);
    step(1, 8'h01, 0, 0);
    step(1, 8'h02, 0, 0);
    first_irq = 0;
    for (int i = 1; i <= 110; i++) begin
      step(0, 8'h00, 0, 0);
      if (irq && first_irq == 0) first_irq = i;
    end
`ifdef UART_FIFO_TIMEOUT_EN
    chk("timeout_delay", 32'(first_irq), 32'd100);
`else
    chk("timeout_absent", 32'(first_irq), 32'd0);
`endif

    // clr beats a same-cycle write
    step(0, 8'h00, 0, 1);
    step(0, 8'h00, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 8'(8'h60 + i), 0, 0);
    step(1, 8'h77, 0, 1);
    chk("clr_level", 32'(level), 32'd0);
    step(1, 8'h78, 0, 0);
    step(0, 8'h00, 1, 0);
    chk("clr_not_stored", 32'(rd_data), 32'h78);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) step(1, 8'(8'h90 + i), 0, 0);
    @(negedge clk);
    wr_en = 1; wr_data = 8'hEE;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("@async_rst");
    @(negedge clk);
    wr_en = 0;
    rst_n = 1'b1;

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) watermark = LW'($urandom_range(0, 9));
      step(1'($urandom_range(0, 99) < 55), 8'($urandom), 1'($urandom_range(0, 99) < 45),
           1'($urandom_range(0, 99) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
